// File: rtl/ps2_mouse_sequencer_if.sv
// ----------------------------------------------------------------------------
// ps2_mouse_sequencer_if : byte/command link between the mouse sequencer and
// the PS2_Controller.  Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface ps2_mouse_sequencer_if;
  logic [7:0] rx_data;
  logic       rx_data_en;
  logic       cmd_sent;
  logic       cmd_error;
  logic [7:0] cmd_out;
  logic       send_cmd;

  // master = sequencer issuing commands, slave = PS2_Controller side
  modport master (
    input  rx_data, rx_data_en, cmd_sent, cmd_error,
    output cmd_out, send_cmd
  );
  modport slave (
    output rx_data, rx_data_en, cmd_sent, cmd_error,
    input  cmd_out, send_cmd
  );
endinterface

`default_nettype wire

// File: rtl/ps2_mouse_sequencer.sv
// ----------------------------------------------------------------------------
// ps2_mouse_sequencer : enables PS/2 mouse streaming, then decodes 3-byte
// movement packets into buttons, deltas, overflow flags and event strobes.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ps2_mouse_sequencer #(
  parameter int INIT_DELAY   = 5000000,
  parameter int ACK_TIMEOUT  = 2500000,
  parameter int BYTE_TIMEOUT = 1000000,
  parameter int MAX_RETRIES  = 3
) (
  input  wire logic             CLOCK_50,
  input  wire logic             resetn,
  ps2_mouse_sequencer_if.master ps2,
  output logic                  ready,
  output logic                  error,
  output logic                  btn_left,
  output logic                  btn_right,
  output logic                  btn_mid,
  output logic [8:0]            dx,
  output logic [8:0]            dy,
  output logic                  x_ovf,
  output logic                  y_ovf,
  output logic                  packet_valid,
  output logic                  mouse_moved,
  output logic                  click
);

  localparam int MAX_AB    = (INIT_DELAY > ACK_TIMEOUT) ? INIT_DELAY : ACK_TIMEOUT;
  localparam int MAX_PARAM = (MAX_AB > BYTE_TIMEOUT) ? MAX_AB : BYTE_TIMEOUT;
  localparam int CNT_W     = $clog2(MAX_PARAM) + 1;
  localparam int RTY_W     = $clog2(MAX_RETRIES) + 1;

  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_DELAY - 1);
  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BYTE_LAST  = CNT_W'(BYTE_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RETRY_MAX  = RTY_W'(MAX_RETRIES);
  localparam logic [7:0]       CMD_ENABLE = 8'hF4;
  localparam logic [7:0]       RSP_ACK    = 8'hFA;
  localparam logic [7:0]       RSP_RESEND = 8'hFE;

  typedef enum logic [2:0] {
    S_INIT_WAIT = 3'd0,
    S_SEND      = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_RETRY     = 3'd3,
    S_ERROR     = 3'd4,
    S_B0        = 3'd5,
    S_B1        = 3'd6,
    S_B2        = 3'd7
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [RTY_W-1:0] retries;
  logic [7:0]       byte0;
  logic [7:0]       byte1;

  logic [CNT_W-1:0] cnt_inc;
  logic [RTY_W-1:0] retry_next;
  logic [8:0]       new_dx;
  logic [8:0]       new_dy;
  logic [2:0]       new_btn;
  logic [2:0]       old_btn;

  // Counters saturate rather than wrap
  assign cnt_inc    = (&cnt)     ? cnt     : cnt + CNT_W'(1);
  assign retry_next = (&retries) ? retries : retries + RTY_W'(1);

  // byte1 is already registered; byte2 is taken straight from the bus
  assign new_dx  = {byte0[4], byte1};
  assign new_dy  = {byte0[5], ps2.rx_data};
  assign new_btn = byte0[2:0];
  assign old_btn = {btn_mid, btn_right, btn_left};

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state        <= S_INIT_WAIT;
      cnt          <= '0;
      retries      <= '0;
      byte0        <= '0;
      byte1        <= '0;
      ps2.cmd_out  <= CMD_ENABLE;
      ps2.send_cmd <= 1'b0;
      ready        <= 1'b0;
      error        <= 1'b0;
      btn_left     <= 1'b0;
      btn_right    <= 1'b0;
      btn_mid      <= 1'b0;
      dx           <= '0;
      dy           <= '0;
      x_ovf        <= 1'b0;
      y_ovf        <= 1'b0;
      packet_valid <= 1'b0;
      mouse_moved  <= 1'b0;
      click        <= 1'b0;
    end else begin
      packet_valid <= 1'b0;
      mouse_moved  <= 1'b0;
      click        <= 1'b0;
      case (state)
        S_INIT_WAIT: begin
          if (cnt >= INIT_LAST) begin
            state        <= S_SEND;
            ps2.send_cmd <= 1'b1;
            cnt          <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_SEND: begin
          if (ps2.cmd_error) begin
            ps2.send_cmd <= 1'b0;
            state        <= S_RETRY;
          end else if (ps2.cmd_sent) begin
            ps2.send_cmd <= 1'b0;
            cnt          <= '0;
            state        <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (ps2.rx_data_en && ps2.rx_data == RSP_ACK) begin
            state   <= S_B0;
            ready   <= 1'b1;
            retries <= '0;
          end else if (ps2.rx_data_en && ps2.rx_data == RSP_RESEND) begin
            state <= S_RETRY;
          end else if (cnt >= ACK_LAST) begin
            state <= S_RETRY;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_RETRY: begin
          retries <= retry_next;
          if (retry_next >= RETRY_MAX) begin
            state        <= S_ERROR;
            error        <= 1'b1;
            ready        <= 1'b0;
            ps2.send_cmd <= 1'b0;
          end else begin
            state        <= S_SEND;
            ps2.send_cmd <= 1'b1;
          end
        end
        S_ERROR: begin
          state <= S_ERROR;
        end
        S_B0: begin
          // Bit 3 of the first packet byte is always set; anything else is skipped
          if (ps2.rx_data_en && ps2.rx_data[3]) begin
            byte0 <= ps2.rx_data;
            cnt   <= '0;
            state <= S_B1;
          end
        end
        S_B1: begin
          if (ps2.rx_data_en) begin
            byte1 <= ps2.rx_data;
            cnt   <= '0;
            state <= S_B2;
          end else if (cnt >= BYTE_LAST) begin
            state <= S_B0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_B2: begin
          if (ps2.rx_data_en) begin
            btn_left     <= new_btn[0];
            btn_right    <= new_btn[1];
            btn_mid      <= new_btn[2];
            dx           <= new_dx;
            dy           <= new_dy;
            x_ovf        <= byte0[6];
            y_ovf        <= byte0[7];
            packet_valid <= 1'b1;
            mouse_moved  <= (new_dx != 9'd0) || (new_dy != 9'd0);
            click        <= |(new_btn & ~old_btn);
            state        <= S_B0;
          end else if (cnt >= BYTE_LAST) begin
            state <= S_B0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= S_INIT_WAIT;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_mouse_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ps2_mouse_sequencer : scoreboard bench for ps2_mouse_sequencer with a
// packet-level reference model.  Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ps2_mouse_sequencer;
  localparam int INIT_DELAY   = 10;
  localparam int ACK_TIMEOUT  = 20;
  localparam int BYTE_TIMEOUT = 30;
  localparam int MAX_RETRIES  = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ps2_mouse_sequencer_if bus ();

  logic       ready, error, btn_left, btn_right, btn_mid;
  logic [8:0] dx, dy;
  logic       x_ovf, y_ovf, packet_valid, mouse_moved, click;

  ps2_mouse_sequencer #(
    .INIT_DELAY  (INIT_DELAY),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .BYTE_TIMEOUT(BYTE_TIMEOUT),
    .MAX_RETRIES (MAX_RETRIES)
  ) dut (
    .CLOCK_50    (clk),
    .resetn      (resetn),
    .ps2         (bus),
    .ready       (ready),
    .error       (error),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_mid     (btn_mid),
    .dx          (dx),
    .dy          (dy),
    .x_ovf       (x_ovf),
    .y_ovf       (y_ovf),
    .packet_valid(packet_valid),
    .mouse_moved (mouse_moved),
    .click       (click)
  );

  typedef struct {
    int btn;
    int dxv;
    int dyv;
    int ovf;
    int moved;
    int clk_ev;
    int due;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   sends_seen = 0;
  logic prev_send  = 1'b0;
  logic prev_pv    = 1'b0;
  int   prev_btn_model = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.send_cmd && !prev_send) sends_seen <= sends_seen + 1;
    prev_send <= bus.send_cmd;
  end

  // Monitor: pops the expected packet whenever the DUT strobes one
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (resetn) begin
      if (packet_valid) begin
        check("strobe_single_cycle", int'(prev_pv), 0);
        if (q.size() == 0) begin
          check("unexpected_packet", 1, 0);
        end else begin
          e = q.pop_front();
          check("buttons", int'({btn_mid, btn_right, btn_left}), e.btn);
          check("dx", int'($signed(dx)), e.dxv);
          check("dy", int'($signed(dy)), e.dyv);
          check("ovf", int'({y_ovf, x_ovf}), e.ovf);
          check("mouse_moved", int'(mouse_moved), e.moved);
          check("click", int'(click), e.clk_ev);
          check("latency_cycle", cyc, e.due);
        end
      end else if (mouse_moved || click) begin
        check("orphan_strobe", int'({mouse_moved, click}), 0);
      end
      prev_pv = packet_valid;
    end else begin
      prev_pv = 1'b0;
    end
  end

  // Reference model: packet fields straight from the PS/2 packet layout
  function automatic exp_t model(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    exp_t e;
    int   nb;
    nb       = int'(b0[2:0]);
    e.btn    = nb;
    e.dxv    = b0[4] ? int'(b1) - 256 : int'(b1);
    e.dyv    = b0[5] ? int'(b2) - 256 : int'(b2);
    e.ovf    = (b0[7] ? 2 : 0) + (b0[6] ? 1 : 0);
    e.moved  = (e.dxv != 0 || e.dyv != 0) ? 1 : 0;
    e.clk_ev = ((nb & ~prev_btn_model) != 0) ? 1 : 0;
    e.due    = 0;
    return e;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data    = b;
    bus.rx_data_en = 1'b1;
    @(negedge clk);
    bus.rx_data_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int gap);
    exp_t e;
    send_byte(b0);
    idle(gap);
    send_byte(b1);
    idle(gap);
    e = model(b0, b1, b2);
    prev_btn_model = e.btn;
    @(negedge clk);
    e.due = cyc + 1;
    q.push_back(e);
    bus.rx_data    = b2;
    bus.rx_data_en = 1'b1;
    @(negedge clk);
    bus.rx_data_en = 1'b0;
  endtask

  task automatic pulse_sent();
    @(negedge clk);
    bus.cmd_sent = 1'b1;
    @(negedge clk);
    bus.cmd_sent = 1'b0;
  endtask

  task automatic wait_send(input int limit, output int waited);
    waited = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (bus.send_cmd) begin
        waited = i;
        break;
      end
    end
  endtask

  // Release reset, feed the self-test bytes, and time the first command
  task automatic startup(input string tag);
    int c0;
    int w;
    @(negedge clk);
    resetn = 1'b1;
    c0 = cyc;
    send_byte(8'hAA);
    send_byte(8'h00);
    wait_send(INIT_DELAY + 20, w);
    check({tag, "_send_seen"}, int'(w > 0), 1);
    check({tag, "_send_cycle"}, cyc - c0, INIT_DELAY);
    check({tag, "_cmd_out"}, int'(bus.cmd_out), 'hF4);
  endtask

  function automatic int all_outs();
    return int'({ready, error, bus.send_cmd, btn_left, btn_right, btn_mid,
                 x_ovf, y_ovf, packet_valid, mouse_moved, click, dx, dy});
  endfunction

  initial begin
    int w;
    int kind;
    int base;
    bus.rx_data    = 8'h00;
    bus.rx_data_en = 1'b0;
    bus.cmd_sent   = 1'b0;
    bus.cmd_error  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    check("reset_cmd_out", int'(bus.cmd_out), 'hF4);

    startup("init");
    pulse_sent();
    check("send_drop_after_sent", int'(bus.send_cmd), 0);
    send_byte(8'h12);
    check("ready_before_ack", int'(ready), 0);
    send_byte(8'hFA);
    @(negedge clk);
    check("ready_after_ack", int'(ready), 1);
    check("send_after_ack", int'(bus.send_cmd), 0);

    send_packet(8'h09, 8'h05, 8'hFB, 0);
    send_byte(8'h02);
    send_packet(8'h38, 8'hFF, 8'hFE, 1);
    send_byte(8'h08);
    send_byte(8'h01);
    idle(BYTE_TIMEOUT + 5);
    send_packet(8'h08, 8'h00, 8'h00, 0);

    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 5);
      if (kind == 0) begin
        send_byte(8'($urandom) & 8'hF7);
      end else if (kind == 1) begin
        send_byte(8'($urandom) | 8'h08);
        if ($urandom_range(0, 1) == 1) send_byte(8'($urandom));
        idle(BYTE_TIMEOUT + 5);
      end
      send_packet(8'($urandom) | 8'h08, 8'($urandom), 8'($urandom), $urandom_range(0, 8));
    end
    send_packet(8'hFF, 8'h33, 8'h44, 2);
    idle(3);

    send_byte(8'h08);
    send_byte(8'h01);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 0);
    check("async_reset_cmd_out", int'(bus.cmd_out), 'hF4);
    prev_btn_model = 0;
    base = sends_seen;
    idle(2);

    startup("reinit");
    @(negedge clk);
    bus.cmd_error = 1'b1;
    bus.cmd_sent  = 1'b1;
    @(negedge clk);
    bus.cmd_error = 1'b0;
    bus.cmd_sent  = 1'b0;
    wait_send(10, w);
    check("retry2_send", int'(w > 0), 1);
    pulse_sent();
    send_byte(8'hFE);
    wait_send(10, w);
    check("retry3_send", int'(w > 0), 1);
    pulse_sent();
    for (int i = 0; i < ACK_TIMEOUT + 20; i++) begin
      @(negedge clk);
      if (error) break;
    end
    check("error_set", int'(error), 1);
    idle(2 * ACK_TIMEOUT);
    check("transmissions", sends_seen - base, MAX_RETRIES);
    check("error_ready", int'(ready), 0);
    check("error_send", int'(bus.send_cmd), 0);
    send_byte(8'hFA);
    idle(3);
    check("error_sticky", int'({error, ready}), 2);

    idle(5);
    check("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
